lzw_char_shifter: RTL and testbench
===================================

Name: lzw_char_shifter

Overview:
Parametrised successor to the fixed 64-bit character shift register that feeds the LZW dictionary stage.
- Loads a packed word of up to MAX_CHARS characters plus a character count.
- Emits one character per accepted beat, zero-extended to CODE_W, over a valid/ready handshake.
- Adds what the earlier block lacked: backpressure, a last-beat flag, a done pulse and generic widths.
- Sits between the input byte buffer and the LZW dictionary-lookup FSM.

Parameters:
CHAR_W, 8, bits per character
MAX_CHARS, 8, maximum characters per load word
CODE_W, 12, output code width; must be >= CHAR_W
CNT_W, $clog2(MAX_CHARS), width of num_char (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
cs  input  1  load strobe; sampled only when in_ready=1
data_in  input  MAX_CHARS*CHAR_W  packed characters, valid characters low-aligned
num_char  input  CNT_W  number of valid characters minus 1 (0 = one character)
in_ready  output  1  high in IDLE only
data_out  output  CODE_W  current character, zero-extended
out_valid  output  1  data_out holds a valid character
out_ready  input  1  downstream accepts the beat
out_last  output  1  current beat is the final character of the word
state_out  output  1  busy: high in SHIFT or DONE
done  output  1  one-cycle pulse after the last beat transfers

Behaviour:
- Reset (rst=0, async): state=IDLE; shift register=0, count=0, data_out=0, out_valid=0, out_last=0, done=0, state_out=0, in_ready=1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on cs=1.
  - Latch data_in into the shift register; latch count=num_char.
  - Load the first character so it appears on data_out with out_valid=1 the next cycle (1-cycle load latency).
- Character order (default): most-significant valid character first, i.e. data_in[(num_char+1)*CHAR_W-1 -: CHAR_W].
  - Last character is data_in[CHAR_W-1:0].
  - Bits above (num_char+1)*CHAR_W are ignored.
- Handshake: a beat transfers when out_valid && out_ready.
  - Without a transfer, data_out, out_valid and out_last hold stable.
  - On transfer with count>0: shift by CHAR_W, decrement count, present the next character on the next cycle. No bubble, one beat per cycle under full ready.
  - out_last = (count==0) while out_valid.
- On transfer of the last beat: SHIFT -> DONE. out_valid=0, done=1 for exactly one cycle, then DONE -> IDLE.
- cs outside IDLE is ignored; no queuing.
- Width rule: data_out = {(CODE_W-CHAR_W) zeros, char}.
- Reset asserted mid-word aborts immediately. No done pulse; the partial word is discarded.
- Latency: load to first valid = 1 cycle. Minimum IDLE-to-IDLE for an N-char word under constant ready = N+2 cycles.

Optional Feature:
LSB_FIRST_EN
- Defined: characters are emitted from data_in[CHAR_W-1:0] upward, and the shift direction reverses. out_last still marks the (num_char+1)th beat.
- Undefined: MSB-first order as above.
- Ports and timing are identical in both builds.

Decomposition:
- Package lzw_pkg: state enum (IDLE, SHIFT, DONE), default CHAR_W/CODE_W/MAX_CHARS localparams, and a function zext_char().
- No sub-module required. A single-file FSM plus shift register is natural; the shift register is not split out.

Test Plan:
- num_char=7, data_in=64'h62616E6A6F696E67, out_ready=1 -> data_out 0x062,0x061,0x06E,0x06A,0x06F,0x069,0x06E,0x067 on consecutive cycles. out_last on 0x067; done pulses 1 cycle later; in_ready returns the following cycle.
- num_char=0, data_in low byte 0xE3 (upper bits garbage) -> single beat 0x0E3 with out_last=1, then done.
- num_char=1, data_in low 16 bits 0x2CE3 -> beats 0x02C then 0x0E3. With LSB_FIRST_EN: 0x0E3 then 0x02C.
- Backpressure: out_ready=0 for 3 cycles on the 2nd beat of the 8-char word -> data_out holds 0x061 and out_valid holds 1. Sequence is resumed without loss or duplication.
- cs pulsed with new data_in while in SHIFT -> ignored; original sequence unaffected.
- rst driven low during the 4th beat -> all outputs 0 asynchronously, no done. After release, a new cs load of 0x2CE3/num_char=1 produces 0x02C, 0x0E3 correctly.

Source files
------------

// File: rtl/lzw_pkg.sv
// Shared types and helpers for the LZW character shifter.
package lzw_pkg;

  localparam int unsigned LZW_CHAR_W    = 8;
  localparam int unsigned LZW_MAX_CHARS = 8;
  localparam int unsigned LZW_CODE_W    = 12;
  localparam int unsigned ZEXT_W        = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Keep only the low char_w bits so the caller's truncating cast yields a zero-extended code.
  function automatic logic [ZEXT_W-1:0] zext_char(input logic [ZEXT_W-1:0] raw,
                                                  input int unsigned     char_w);
    logic [ZEXT_W-1:0] mask;
    mask = (char_w >= ZEXT_W) ? '1 : ((ZEXT_W'(1) << char_w) - ZEXT_W'(1));
    return raw & mask;
  endfunction

endpackage

// File: rtl/lzw_char_shifter_if.sv
// Load/beat handshake bundle between the byte buffer, the shifter and the dictionary FSM.
interface lzw_char_shifter_if
  import lzw_pkg::*;
#(
  parameter int unsigned CHAR_W    = LZW_CHAR_W,
  parameter int unsigned MAX_CHARS = LZW_MAX_CHARS,
  parameter int unsigned CODE_W    = LZW_CODE_W
);
  localparam int unsigned DATA_W = MAX_CHARS * CHAR_W;
  localparam int unsigned CNT_W  = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

  logic              cs;
  logic [DATA_W-1:0] data_in;
  logic [CNT_W-1:0]  num_char;
  logic              in_ready;
  logic [CODE_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              state_out;
  logic              done;

  modport slave (
    input  cs, data_in, num_char, out_ready,
    output in_ready, data_out, out_valid, out_last, state_out, done
  );

  modport master (
    output cs, data_in, num_char, out_ready,
    input  in_ready, data_out, out_valid, out_last, state_out, done
  );

endinterface

// File: rtl/lzw_char_shifter.sv
// Word-to-character shifter feeding the LZW dictionary stage, one character per accepted beat.
// Build option LSB_FIRST_EN: emit characters from data_in[CHAR_W-1:0] upward instead of MSB-first.
module lzw_char_shifter
  import lzw_pkg::*;
#(
  parameter int unsigned CHAR_W    = LZW_CHAR_W,
  parameter int unsigned MAX_CHARS = LZW_MAX_CHARS,
  parameter int unsigned CODE_W    = LZW_CODE_W
) (
  input  logic                clk,
  input  logic                rst,
  lzw_char_shifter_if.slave   bus
);

  localparam int unsigned DATA_W   = MAX_CHARS * CHAR_W;
  localparam int unsigned CNT_W    = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int unsigned TOP_CHAR = MAX_CHARS - 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic [CNT_W-1:0]  load_cnt;
  logic [CHAR_W-1:0] load_char;
  logic [DATA_W-1:0] load_rest;
  logic [CHAR_W-1:0] next_char;
  logic [DATA_W-1:0] next_rest;
  logic              xfer;

  // A count field wider than the word can name characters that do not exist; saturate it.
  if ((1 << CNT_W) > MAX_CHARS) begin : g_clamp
    assign load_cnt = (32'(bus.num_char) > TOP_CHAR) ? CNT_W'(TOP_CHAR) : bus.num_char;
  end else begin : g_noclamp
    assign load_cnt = bus.num_char;
  end

  assign xfer = out_valid_q && bus.out_ready;

`ifdef LSB_FIRST_EN
  always_comb begin
    load_char = bus.data_in[CHAR_W-1:0];
    load_rest = bus.data_in >> CHAR_W;
    next_char = shreg_q[CHAR_W-1:0];
    next_rest = shreg_q >> CHAR_W;
  end
`else
  // Left-justify the valid characters so the first one sits at the top and garbage falls off.
  logic [DATA_W-1:0] load_word;
  int unsigned       load_shamt;

  always_comb begin
    load_shamt = CHAR_W * (TOP_CHAR - 32'(load_cnt));
    load_word  = bus.data_in << load_shamt;
    load_char  = load_word[DATA_W-1 -: CHAR_W];
    load_rest  = load_word << CHAR_W;
    next_char  = shreg_q[DATA_W-1 -: CHAR_W];
    next_rest  = shreg_q << CHAR_W;
  end
`endif

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cs) begin
          state_d     = SHIFT;
          shreg_d     = load_rest;
          cnt_d       = load_cnt;
          data_out_d  = CODE_W'(zext_char(ZEXT_W'(load_char), CHAR_W));
          out_valid_d = 1'b1;
          out_last_d  = (load_cnt == '0);
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (cnt_q == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            shreg_d    = next_rest;
            cnt_d      = cnt_q - CNT_W'(1);
            data_out_d = CODE_W'(zext_char(ZEXT_W'(next_char), CHAR_W));
            out_last_d = (cnt_q == CNT_W'(1));
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.state_out = busy_q;

endmodule

// File: tb/tb_lzw_char_shifter.sv
// Directed bench for lzw_char_shifter with a beat scoreboard checked on the falling edge.
module tb_lzw_char_shifter;

  typedef struct packed {
    logic [11:0] code;
    logic        last;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    errors = 0;
  int    checks = 0;
  beat_t sb[$];
  beat_t hold_exp;

  lzw_char_shifter_if #(.CHAR_W(8), .MAX_CHARS(8), .CODE_W(12)) bus ();

  lzw_char_shifter #(.CHAR_W(8), .MAX_CHARS(8), .CODE_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ordering of the characters of one load word.
  task automatic push_word(input logic [63:0] d, input int n);
    beat_t e;
    int    idx;
    for (int k = 0; k <= n; k++) begin
`ifdef LSB_FIRST_EN
      idx = k;
`else
      idx = n - k;
`endif
      e.code = {4'h0, d[idx*8 +: 8]};
      e.last = (k == n);
      sb.push_back(e);
    end
  endtask

  task automatic load(input logic [63:0] d, input int n);
    int w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    chk("in_ready_before_load", 64'(bus.in_ready), 64'd1);
    push_word(d, n);
    bus.cs       = 1'b1;
    bus.data_in  = d;
    bus.num_char = 3'(n);
    tick();
    bus.cs      = 1'b0;
    bus.data_in = 64'h0;
    chk("valid_after_load", 64'(bus.out_valid), 64'd1);
    chk("busy_after_load", 64'(bus.state_out), 64'd1);
    chk("in_ready_low_busy", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic wait_done(input int exp_cyc);
    int cyc  = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 100) begin
      tick();
      cyc++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++;
    assert (seen)
    else begin
      errors++;
      $error("FAIL done_timeout: observed no done in %0d cycles, expected after %0d", cyc, exp_cyc);
    end
    if (seen) begin
      chk("done_latency", 64'(cyc), 64'(exp_cyc));
      chk("valid_low_in_done", 64'(bus.out_valid), 64'd0);
      chk("in_ready_low_in_done", 64'(bus.in_ready), 64'd0);
      tick();
      chk("done_one_cycle", 64'(bus.done), 64'd0);
      chk("in_ready_back", 64'(bus.in_ready), 64'd1);
      chk("busy_clear", 64'(bus.state_out), 64'd0);
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  // Every transferring beat must match the head of the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL extra_beat: observed data_out=%0h with empty scoreboard, expected no beat",
               bus.data_out);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat_data", 64'(bus.data_out), 64'(e.code));
        chk("beat_last", 64'(bus.out_last), 64'(e.last));
      end
    end
  end

  initial begin
    bus.cs        = 1'b0;
    bus.data_in   = 64'h0;
    bus.num_char  = 3'd0;
    bus.out_ready = 1'b0;

    // Reset values
    #1 rst = 1'b0;
    #1;
    chk("rst_data_out", 64'(bus.data_out), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_state_out", 64'(bus.state_out), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    tick();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    // Eight characters under full ready
    load(64'h62616E6A6F696E67, 7);
    chk("first_not_last", 64'(bus.out_last), 64'd0);
    wait_done(8);

    // Single character with garbage above it
    load(64'hDEADBEEF123456E3, 0);
    chk("single_is_last", 64'(bus.out_last), 64'd1);
    wait_done(1);

    // Two characters
    load(64'hA5A5A5A5A5A52CE3, 1);
    wait_done(2);

    // Backpressure on the second beat
    load(64'h62616E6A6F696E67, 7);
    tick();
    bus.out_ready = 1'b0;
    hold_exp = sb[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data", 64'(bus.data_out), 64'(hold_exp.code));
      chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_last", 64'(bus.out_last), 64'(hold_exp.last));
    end
    bus.out_ready = 1'b1;
    wait_done(7);

    // Load strobe while busy is ignored
    load(64'h62616E6A6F696E67, 7);
    tick();
    tick();
    bus.cs       = 1'b1;
    bus.data_in  = 64'h1122334455667788;
    bus.num_char = 3'd3;
    tick();
    bus.cs = 1'b0;
    chk("cs_busy_in_ready", 64'(bus.in_ready), 64'd0);
    wait_done(5);
    tick();
    chk("no_queued_load", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset during the fourth beat
    load(64'h62616E6A6F696E67, 7);
    tick();
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("abort_data_out", 64'(bus.data_out), 64'd0);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_out_last", 64'(bus.out_last), 64'd0);
    chk("abort_state_out", 64'(bus.state_out), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    tick();
    chk("abort_no_done", 64'(bus.done), 64'd0);
    rst = 1'b1;
    tick();
    chk("post_abort_no_done", 64'(bus.done), 64'd0);
    load(64'h0000000000002CE3, 1);
    wait_done(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
